instr_encoder: RTL and testbench
================================

# instr_encoder

Inverse of the control decoder's instruction decode. It accepts encode requests carrying the decoder's internal `aluOP` code plus register and immediate fields. It assembles the matching 32-bit RV32 instruction word and streams it into instruction memory through a valid/ready write port with an auto-incrementing word address. It is used by the program loader and self-test harness to build programs in IMEM from the same operation codes the datapath consumes.

## Interface
Parameters:
- `DEPTH`, 256: IMEM capacity in words; number of writes allowed before `full`.
- `ADDR_W`, 8: width of `wr_addr`; `2**ADDR_W >= DEPTH`.

Ports:
- `clk` in 1: the single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `restart` in 1: synchronous clear of the address, pending word and error state.
- `req_valid` in 1: encode request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_aluop` in 6: operation code in the decoder numbering.
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register fields.
- `req_imm` in 12: immediate in two's complement.
- `wr_valid` out 1: IMEM write pending.
- `wr_ready` in 1: IMEM accepts the write when `wr_valid && wr_ready`.
- `wr_addr` out ADDR_W: word address of the pending write.
- `wr_data` out 32: encoded instruction.
- `full` out 1: `DEPTH` words written.
- `err_pulse` out 1: one-cycle pulse, an invalid code was accepted.
- `err_sticky` out 1: set on any invalid code; cleared only by reset or `restart`.

## Operation
Encoding by `req_aluop`:
- **0..4 (LB, LH, LW, LD, LBU):** opcode 0000011; funct3 = code 0..4; I-type with `imm[11:0]` in bits [31:20].
- **5..13 (ADDI, SLLI, SLTI, SLTIU, XORI, SRLI, SRAI, ORI, ANDI):** opcode 0010011.
  - funct3 is 0, 1, 2, 3, 4, 5, 5, 6, 7 respectively.
  - Shifts (6, 10, 11): bits [24:20] = `imm[4:0]`; bits [31:25] = 0000000, except SRAI (11) uses 0100000. `imm[11:5]` is ignored.
- **15..17 (SB, SH, SW):** opcode 0100011; funct3 0/1/2; S-type split, `imm[11:5]` to [31:25] and `imm[4:0]` to [11:7]; `req_rd` ignored.
- **18..27 (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND):** opcode 0110011.
  - funct3 is 0, 0, 1, 2, 3, 4, 5, 5, 6, 7 respectively.
  - funct7 is 0100000 for SUB (19) and SRA (25), else 0; `req_imm` ignored.
- **35 (JALR):** opcode 1100111; funct3 000; I-type.
- **All other codes (14, 28..34, 36..63):** invalid.
  - The request is still accepted (handshake completes).
  - No write occurs; the address does not advance.
  - `err_pulse` fires for one cycle; `err_sticky` is set.
- Fields not used by a format read as 0 in `wr_data`.

Write pipeline:
- One output holding register (`wr_valid`, `wr_addr`, `wr_data`).
- `word_cnt` (ADDR_W+1 bits) counts completed writes; `wr_addr = word_cnt[ADDR_W-1:0]`.
- `word_cnt` increments on each `wr_valid && wr_ready`.
- `full = (word_cnt == DEPTH)`.
- `req_ready = !restart && (!wr_valid || wr_ready) && (word_cnt + wr_valid < DEPTH)`. The pending word is counted, so the counter never wraps.
- `wr_data`, `wr_addr` and `wr_valid` hold stable while `wr_valid && !wr_ready`.

Restart:
- `restart` has priority over every other event in the same cycle.
- `wr_valid` goes to 0 and the pending word is dropped, even if `wr_ready` is 1 that cycle.
- `word_cnt`, `err_sticky` and `err_pulse` go to 0.
- No request is accepted in that cycle.

Reset (async assert, deassert synchronized externally):
- `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `full` 0, `err_pulse` 0, `err_sticky` 0.
- `req_ready` = 1 once `rst_n` is high (`DEPTH` ≥ 1, no restart).
- Reset mid-transfer discards the pending word.

## Timing
- Latency: a request accepted at edge N presents `wr_valid`/`wr_data` after edge N, i.e. in cycle N+1. `err_pulse` for an invalid code is likewise high in cycle N+1 only.
- Throughput: one instruction per cycle while `wr_ready` stays high.
- Backpressure propagates combinationally: `req_ready` falls in the same cycle `wr_ready` is low with a word pending.
- `full` rises in the cycle after the `DEPTH`-th write handshake. Requests are blocked from the cycle the final word becomes pending.

## Test plan
- **Basic I-type and JALR:** ADDI x1,x0,5 (aluop 5, rd 1, rs1 0, imm 5) -> `wr_data` 0x00500093 at `wr_addr` 0 in the cycle after accept. Then JALR x1,0(x2) (aluop 35) -> 0x000100E7 at addr 1.
- **R-type funct7:** SUB x3,x1,x2 (aluop 19) -> 0x402081B3.
- **Shift immediate:** SRAI x5,x5,3 (aluop 11, imm 0xFE3) -> 0x4032D293; upper imm bits ignored.
- **S-type split:** SW x2,-4(x1) (aluop 17, rs1 1, rs2 2, imm 0xFFC) -> 0xFE20AE23.
- **Backpressure and invalid code:**
  - Back-to-back stream with `wr_ready` low for 3 cycles -> `wr_data`/`wr_addr` stable and `req_ready` 0 throughout; no word lost or duplicated; addresses consecutive.
  - aluop 14 -> accepted, `err_pulse` high exactly 1 cycle, `err_sticky` 1, no write, next valid word reuses the same address.
- **Full and restart (`DEPTH`=4):**
  - Four writes -> `full` 1 and `req_ready` 0; a fifth request is held.
  - `restart` asserted while a word is pending with `wr_ready` 1 -> no write that cycle; `wr_addr` 0, `full` 0, `err_sticky` 0 next cycle.
  - Async `rst_n` low mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Bundles the encode-request channel, the IMEM write channel and the status
// flags of instr_encoder so loader, memory model and encoder share one port.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_aluop;
  logic [4:0]        req_rd;
  logic [4:0]        req_rs1;
  logic [4:0]        req_rs2;
  logic [11:0]       req_imm;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  logic              full;
  logic              err_pulse;
  logic              err_sticky;

  // Loader and IMEM side: issues requests, consumes writes.
  modport master (
    output req_valid, req_aluop, req_rd, req_rs1, req_rs2, req_imm, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, full, err_pulse, err_sticky
  );

  // Encoder side: accepts requests, produces writes and status.
  modport slave (
    input  req_valid, req_aluop, req_rd, req_rs1, req_rs2, req_imm, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, full, err_pulse, err_sticky
  );
endinterface

// File: rtl/instr_encoder.sv
// Turns decoder aluOP codes plus register/immediate fields back into RV32
// instruction words and streams them into IMEM at consecutive word addresses.
module instr_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          restart,
  instr_encoder_if.slave bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] F7_ALT   = 7'b0100000;

  localparam logic [ADDR_W+1:0] DEPTH_W = (ADDR_W+2)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_SHIFT,
    FMT_S,
    FMT_R
  } fmt_e;

  fmt_e              fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       enc_word;
  logic              enc_ok;

  logic              wr_valid_q, wr_valid_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;

  logic [ADDR_W+1:0] committed;
  logic              req_ready;
  logic              req_fire;
  logic              write_fire;

  // Classify the operation code into an instruction format and its fixed fields.
  always_comb begin
    fmt    = FMT_NONE;
    opcode = 7'd0;
    funct3 = 3'd0;
    funct7 = 7'd0;
    case (bus.req_aluop)
      6'd0:  begin fmt = FMT_I;     opcode = OP_LOAD;  funct3 = 3'd0; end
      6'd1:  begin fmt = FMT_I;     opcode = OP_LOAD;  funct3 = 3'd1; end
      6'd2:  begin fmt = FMT_I;     opcode = OP_LOAD;  funct3 = 3'd2; end
      6'd3:  begin fmt = FMT_I;     opcode = OP_LOAD;  funct3 = 3'd3; end
      6'd4:  begin fmt = FMT_I;     opcode = OP_LOAD;  funct3 = 3'd4; end
      6'd5:  begin fmt = FMT_I;     opcode = OP_IMM;   funct3 = 3'd0; end
      6'd6:  begin fmt = FMT_SHIFT; opcode = OP_IMM;   funct3 = 3'd1; end
      6'd7:  begin fmt = FMT_I;     opcode = OP_IMM;   funct3 = 3'd2; end
      6'd8:  begin fmt = FMT_I;     opcode = OP_IMM;   funct3 = 3'd3; end
      6'd9:  begin fmt = FMT_I;     opcode = OP_IMM;   funct3 = 3'd4; end
      6'd10: begin fmt = FMT_SHIFT; opcode = OP_IMM;   funct3 = 3'd5; end
      6'd11: begin fmt = FMT_SHIFT; opcode = OP_IMM;   funct3 = 3'd5; funct7 = F7_ALT; end
      6'd12: begin fmt = FMT_I;     opcode = OP_IMM;   funct3 = 3'd6; end
      6'd13: begin fmt = FMT_I;     opcode = OP_IMM;   funct3 = 3'd7; end
      6'd15: begin fmt = FMT_S;     opcode = OP_STORE; funct3 = 3'd0; end
      6'd16: begin fmt = FMT_S;     opcode = OP_STORE; funct3 = 3'd1; end
      6'd17: begin fmt = FMT_S;     opcode = OP_STORE; funct3 = 3'd2; end
      6'd18: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd0; end
      6'd19: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd0; funct7 = F7_ALT; end
      6'd20: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd1; end
      6'd21: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd2; end
      6'd22: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd3; end
      6'd23: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd4; end
      6'd24: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd5; end
      6'd25: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd5; funct7 = F7_ALT; end
      6'd26: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd6; end
      6'd27: begin fmt = FMT_R;     opcode = OP_REG;   funct3 = 3'd7; end
      6'd35: begin fmt = FMT_I;     opcode = OP_JALR;  funct3 = 3'd0; end
      default: begin fmt = FMT_NONE; end
    endcase
  end

  // Pack the request fields according to the selected format; unused fields stay zero.
  always_comb begin
    enc_ok   = 1'b1;
    enc_word = 32'd0;
    case (fmt)
      FMT_I:     enc_word = {bus.req_imm, bus.req_rs1, funct3, bus.req_rd, opcode};
      FMT_SHIFT: enc_word = {funct7, bus.req_imm[4:0], bus.req_rs1, funct3, bus.req_rd, opcode};
      FMT_S:     enc_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, funct3,
                             bus.req_imm[4:0], opcode};
      FMT_R:     enc_word = {funct7, bus.req_rs2, bus.req_rs1, funct3, bus.req_rd, opcode};
      default:   enc_ok   = 1'b0;
    endcase
  end

  // Flow control: the pending word counts against capacity so the counter never wraps.
  always_comb begin
    committed  = {1'b0, word_cnt_q} + (ADDR_W+2)'(wr_valid_q);
    req_ready  = !restart && (!wr_valid_q || bus.wr_ready) && (committed < DEPTH_W);
    req_fire   = bus.req_valid && req_ready;
    write_fire = wr_valid_q && bus.wr_ready;
  end

  // Next state of the output register, write counter and error flags; restart overrides all.
  always_comb begin
    wr_valid_d   = wr_valid_q;
    wr_data_d    = wr_data_q;
    word_cnt_d   = word_cnt_q;
    err_pulse_d  = 1'b0;
    err_sticky_d = err_sticky_q;
    if (restart) begin
      wr_valid_d   = 1'b0;
      word_cnt_d   = '0;
      err_sticky_d = 1'b0;
    end else begin
      if (write_fire) begin
        word_cnt_d = word_cnt_q + 1'b1;
        wr_valid_d = 1'b0;
      end
      if (req_fire) begin
        if (enc_ok) begin
          wr_valid_d = 1'b1;
          wr_data_d  = enc_word;
        end else begin
          err_pulse_d  = 1'b1;
          err_sticky_d = 1'b1;
        end
      end
    end
  end

  // State registers; reset discards any pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid_q   <= 1'b0;
      wr_data_q    <= 32'd0;
      word_cnt_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      word_cnt_q   <= word_cnt_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_addr    = word_cnt_q[ADDR_W-1:0];
  assign bus.full       = (word_cnt_q == DEPTH_W[ADDR_W:0]);
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a small capacity so full/restart are
// reachable; a behavioural model of the encoder is compared on every cycle.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk;
  logic rst_n;
  logic restart;

  int tests;
  int failures;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .bus     (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned imm_f3 [9]  = '{0, 1, 2, 3, 4, 5, 5, 6, 7};
  int unsigned reg_f3 [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  // Reference encoding from field positions as plain arithmetic; bit 32 = code valid.
  function automatic logic [32:0] model_encode(input int unsigned op, input int unsigned rd,
                                               input int unsigned rs1, input int unsigned rs2,
                                               input int unsigned imm);
    int unsigned w;
    bit ok;
    ok = 1'b1;
    w  = 0;
    if (op <= 4)
      w = 3 + rd * 128 + op * 4096 + rs1 * 32768 + imm * 1048576;
    else if (op <= 13) begin
      if (op == 6 || op == 10 || op == 11)
        w = 19 + rd * 128 + imm_f3[op-5] * 4096 + rs1 * 32768 + (imm % 32) * 1048576
            + ((op == 11) ? 32 * 33554432 : 0);
      else
        w = 19 + rd * 128 + imm_f3[op-5] * 4096 + rs1 * 32768 + imm * 1048576;
    end else if (op >= 15 && op <= 17)
      w = 35 + (imm % 32) * 128 + (op - 15) * 4096 + rs1 * 32768 + rs2 * 1048576
          + (imm / 32) * 33554432;
    else if (op >= 18 && op <= 27)
      w = 51 + rd * 128 + reg_f3[op-18] * 4096 + rs1 * 32768 + rs2 * 1048576
          + ((op == 19 || op == 25) ? 32 * 33554432 : 0);
    else if (op == 35)
      w = 103 + rd * 128 + rs1 * 32768 + imm * 1048576;
    else
      ok = 1'b0;
    return {ok, w};
  endfunction

  bit          m_pending;
  int unsigned m_word;
  int          m_count;
  bit          m_pulse;
  bit          m_sticky;
  bit          m_ready;
  logic [32:0] m_enc;

  // Model view of the request currently on the bus and whether it can be taken.
  always_comb begin
    m_enc   = model_encode(32'(bus.req_aluop), 32'(bus.req_rd), 32'(bus.req_rs1),
                           32'(bus.req_rs2), 32'(bus.req_imm));
    m_ready = !restart && (!m_pending || bus.wr_ready) && (m_count + int'(m_pending) < DEPTH);
  end

  // Model state: one pending word, count of words handed to IMEM, error flags.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_word    <= 0;
      m_count   <= 0;
      m_pulse   <= 1'b0;
      m_sticky  <= 1'b0;
    end else if (restart) begin
      m_pending <= 1'b0;
      m_count   <= 0;
      m_pulse   <= 1'b0;
      m_sticky  <= 1'b0;
    end else begin
      m_count <= m_count + ((m_pending && bus.wr_ready) ? 1 : 0);
      m_pulse <= bus.req_valid && m_ready && !m_enc[32];
      if (bus.req_valid && m_ready && !m_enc[32]) m_sticky <= 1'b1;
      if (bus.req_valid && m_ready && m_enc[32]) begin
        m_pending <= 1'b1;
        m_word    <= m_enc[31:0];
      end else if (m_pending && bus.wr_ready) begin
        m_pending <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request and hold it until accepted; returns one step after the accepting edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [11:0] imm, input int budget);
    bit got;
    got           = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_aluop = op;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      tests++;
      failures++;
      $display("[TB] FAIL accept_timeout: aluop %0d not accepted within %0d cycles", op, budget);
    end
    bus.req_valid = 1'b0;
  endtask

  // Cycle-by-cycle comparison of all outputs against the model, away from the rising edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      checkOutput("cyc_wr_valid", 64'(bus.wr_valid), 64'(m_pending));
      checkOutput("cyc_wr_addr", 64'(bus.wr_addr), 64'(m_count % (1 << ADDR_W)));
      checkOutput("cyc_full", 64'(bus.full), 64'(m_count == DEPTH));
      checkOutput("cyc_err_pulse", 64'(bus.err_pulse), 64'(m_pulse));
      checkOutput("cyc_err_sticky", 64'(bus.err_sticky), 64'(m_sticky));
      checkOutput("cyc_req_ready", 64'(bus.req_ready), 64'(m_ready));
      if (m_pending) checkOutput("cyc_wr_data", 64'(bus.wr_data), 64'(m_word));
    end
  end

  // Hard stop in case the sequence stalls somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence with hand-computed instruction words.
  initial begin
    tests         = 0;
    failures      = 0;
    rst_n         = 1'b0;
    restart       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_aluop = 6'd0;
    bus.req_rd    = 5'd0;
    bus.req_rs1   = 5'd0;
    bus.req_rs2   = 5'd0;
    bus.req_imm   = 12'd0;
    bus.wr_ready  = 1'b1;

    checkOutput("model_addi", 64'(model_encode(5, 1, 0, 0, 5)), 64'({1'b1, 32'h00500093}));
    checkOutput("model_sw", 64'(model_encode(17, 0, 1, 2, 12'hFFC)), 64'({1'b1, 32'hFE20AE23}));
    checkOutput("model_srai", 64'(model_encode(11, 5, 5, 0, 12'hFE3)), 64'({1'b1, 32'h4032D293}));
    checkOutput("model_bad14", 64'(model_encode(14, 1, 1, 1, 1)), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
    checkOutput("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(bus.wr_data), 64'd0);
    checkOutput("rst_full", 64'(bus.full), 64'd0);
    checkOutput("rst_err_pulse", 64'(bus.err_pulse), 64'd0);
    checkOutput("rst_err_sticky", 64'(bus.err_sticky), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Fill the memory back to back.
    applyStimulus(6'd5, 5'd1, 5'd0, 5'd0, 12'd5, 8);
    checkOutput("addi_valid", 64'(bus.wr_valid), 64'd1);
    checkOutput("addi_data", 64'(bus.wr_data), 64'h00500093);
    checkOutput("addi_addr", 64'(bus.wr_addr), 64'd0);
    applyStimulus(6'd35, 5'd1, 5'd2, 5'd0, 12'd0, 8);
    checkOutput("jalr_data", 64'(bus.wr_data), 64'h000100E7);
    checkOutput("jalr_addr", 64'(bus.wr_addr), 64'd1);
    applyStimulus(6'd19, 5'd3, 5'd1, 5'd2, 12'd0, 8);
    checkOutput("sub_data", 64'(bus.wr_data), 64'h402081B3);
    checkOutput("sub_addr", 64'(bus.wr_addr), 64'd2);
    applyStimulus(6'd11, 5'd5, 5'd5, 5'd0, 12'hFE3, 8);
    checkOutput("srai_data", 64'(bus.wr_data), 64'h4032D293);
    checkOutput("srai_addr", 64'(bus.wr_addr), 64'd3);
    checkOutput("last_pending_blocks", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("full_set", 64'(bus.full), 64'd1);
    checkOutput("full_req_ready", 64'(bus.req_ready), 64'd0);

    // A fifth request must be held off, then restart clears everything.
    bus.req_valid = 1'b1;
    bus.req_aluop = 6'd5;
    repeat (3) begin
      @(negedge clk);
      checkOutput("fifth_blocked", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart       = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput("restart_full", 64'(bus.full), 64'd0);
    checkOutput("restart_addr", 64'(bus.wr_addr), 64'd0);

    // Store split, then an invalid code that must not consume an address.
    applyStimulus(6'd17, 5'd0, 5'd1, 5'd2, 12'hFFC, 8);
    checkOutput("sw_data", 64'(bus.wr_data), 64'hFE20AE23);
    checkOutput("sw_addr", 64'(bus.wr_addr), 64'd0);
    applyStimulus(6'd14, 5'd1, 5'd1, 5'd1, 12'd1, 8);
    checkOutput("bad_pulse", 64'(bus.err_pulse), 64'd1);
    checkOutput("bad_sticky", 64'(bus.err_sticky), 64'd1);
    checkOutput("bad_no_write", 64'(bus.wr_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("bad_pulse_once", 64'(bus.err_pulse), 64'd0);
    checkOutput("bad_sticky_hold", 64'(bus.err_sticky), 64'd1);
    applyStimulus(6'd6, 5'd7, 5'd7, 5'd0, 12'hFE2, 8);
    checkOutput("slli_data", 64'(bus.wr_data), 64'h00239393);
    checkOutput("slli_addr", 64'(bus.wr_addr), 64'd1);

    // Restart while a word is pending and IMEM is ready: the word is dropped.
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    checkOutput("rs_pend_valid", 64'(bus.wr_valid), 64'd0);
    checkOutput("rs_pend_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("rs_pend_full", 64'(bus.full), 64'd0);
    checkOutput("rs_pend_sticky", 64'(bus.err_sticky), 64'd0);

    // Backpressure: IMEM stalls for three cycles with a second request waiting.
    bus.wr_ready = 1'b0;
    applyStimulus(6'd18, 5'd1, 5'd2, 5'd3, 12'd0, 8);
    checkOutput("add_data", 64'(bus.wr_data), 64'h003100B3);
    fork
      applyStimulus(6'd23, 5'd4, 5'd1, 5'd2, 12'd0, 10);
      begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("stall_req_ready", 64'(bus.req_ready), 64'd0);
          checkOutput("stall_data", 64'(bus.wr_data), 64'h003100B3);
          checkOutput("stall_addr", 64'(bus.wr_addr), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.wr_ready = 1'b1;
      end
    join
    checkOutput("xor_data", 64'(bus.wr_data), 64'h0020C233);
    checkOutput("xor_addr", 64'(bus.wr_addr), 64'd1);
    applyStimulus(6'd26, 5'd6, 5'd4, 5'd5, 12'd0, 8);
    checkOutput("or_data", 64'(bus.wr_data), 64'h00526333);
    checkOutput("or_addr", 64'(bus.wr_addr), 64'd2);

    // Asynchronous reset in the middle of a stalled transfer.
    bus.wr_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_wr_valid", 64'(bus.wr_valid), 64'd0);
    checkOutput("arst_wr_addr", 64'(bus.wr_addr), 64'd0);
    checkOutput("arst_wr_data", 64'(bus.wr_data), 64'd0);
    checkOutput("arst_full", 64'(bus.full), 64'd0);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.wr_ready = 1'b1;

    applyStimulus(6'd2, 5'd8, 5'd9, 5'd0, 12'h010, 8);
    checkOutput("lw_data", 64'(bus.wr_data), 64'h0104A403);
    checkOutput("lw_addr", 64'(bus.wr_addr), 64'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
